// File: rtl/jvm_insn_framer.sv
// Streaming JVM bytecode framer: splits a byte stream into instruction beats and
// jump-table entry beats, handling the wide prefix and switch padding.
module jvm_insn_framer #(
  parameter int PARAM_LEN = 5,
  parameter int PC_W      = 16,
  parameter int MAX_OPS   = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_kind,
  output logic [7:0]             out_opcode,
  output logic                   out_wide,
  output logic [1:0]             out_pad,
  output logic [PARAM_LEN-1:0]   out_count,
  output logic [8*MAX_OPS-1:0]   out_operands,
  output logic [PC_W-1:0]        out_pc
);

  localparam logic [2:0] S_OPC      = 3'd0;
  localparam logic [2:0] S_WIDE     = 3'd1;
  localparam logic [2:0] S_OPS      = 3'd2;
  localparam logic [2:0] S_PAD      = 3'd3;
  localparam logic [2:0] S_EMIT     = 3'd4;
  localparam logic [2:0] S_ENT      = 3'd5;
  localparam logic [2:0] S_ENT_EMIT = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [PARAM_LEN-1:0]  idx_q, idx_d;
  logic [1:0]            pad_left_q, pad_left_d;
  logic [32:0]           rem_q, rem_d;
  logic                  in_ready_q, in_ready_d;
  logic                  valid_q, valid_d;
  logic                  kind_q, kind_d;
  logic [7:0]            opcode_q, opcode_d;
  logic                  wide_q, wide_d;
  logic [1:0]            pad_q, pad_d;
  logic [PARAM_LEN-1:0]  count_q, count_d;
  logic [8*MAX_OPS-1:0]  ops_q, ops_d;
  logic [PC_W-1:0]       opc_pc_q, opc_pc_d;

  logic                  acc, hs, is_sw;
  logic [1:0]            pad_c;
  logic [31:0]           w_lo, w_hi;
  logic signed [32:0]    diff;
  logic [32:0]           ent_cnt;

  function automatic logic [PARAM_LEN-1:0] op_len(input logic [7:0] op);
    case (op) inside
      8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC:
        op_len = PARAM_LEN'(1);
      8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
      8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7:
        op_len = PARAM_LEN'(2);
      8'hC5:                      op_len = PARAM_LEN'(3);
      8'hB9, 8'hBA, 8'hC8, 8'hC9: op_len = PARAM_LEN'(4);
      8'hAA:                      op_len = PARAM_LEN'(12);
      8'hAB:                      op_len = PARAM_LEN'(8);
      default:                    op_len = '0;
    endcase
  endfunction

  // Header words are big-endian: operand byte 4 is the MSB of the first word.
  always_comb begin
    w_lo = {ops_q[39:32], ops_q[47:40], ops_q[55:48], ops_q[63:56]};
    w_hi = {ops_q[71:64], ops_q[79:72], ops_q[87:80], ops_q[95:88]};
    diff = $signed({w_hi[31], w_hi}) - $signed({w_lo[31], w_lo});
    if (opcode_q == 8'hAA) ent_cnt = diff[32] ? '0 : $unsigned(diff) + 33'd1;
    else                   ent_cnt = ($signed(w_lo) > 32'sd0) ? {w_lo, 1'b0} : '0;
    is_sw = !wide_q && (opcode_q == 8'hAA || opcode_q == 8'hAB);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    idx_d      = idx_q;
    pad_left_d = pad_left_q;
    rem_d      = rem_q;
    kind_d     = kind_q;
    opcode_d   = opcode_q;
    wide_d     = wide_q;
    pad_d      = pad_q;
    count_d    = count_q;
    ops_d      = ops_q;
    opc_pc_d   = opc_pc_q;
    acc        = in_valid && in_ready_q;
    hs         = valid_q && out_ready;
    pad_c      = ~pc_q[1:0];  // (4 - ((pc+1) mod 4)) mod 4

    if (acc) pc_d = pc_q + 1'b1;

    case (state_q)
      S_OPC: if (acc) begin
        kind_d   = 1'b0;
        wide_d   = 1'b0;
        pad_d    = '0;
        ops_d    = '0;
        idx_d    = '0;
        opcode_d = in_byte;
        opc_pc_d = pc_q;
        count_d  = op_len(in_byte);
        if (in_byte == 8'hC4) begin
          state_d = S_WIDE;
        end else if (in_byte == 8'hAA || in_byte == 8'hAB) begin
          pad_d      = pad_c;
          pad_left_d = pad_c;
          state_d    = (pad_c == 2'd0) ? S_OPS : S_PAD;
        end else begin
          state_d = (op_len(in_byte) == '0) ? S_EMIT : S_OPS;
        end
      end
      S_WIDE: if (acc) begin
        opcode_d = in_byte;
        wide_d   = 1'b1;
        if (in_byte == 8'hC4) begin
          count_d = '0;
          state_d = S_EMIT;
        end else begin
          count_d = (in_byte == 8'h84) ? PARAM_LEN'(4) : PARAM_LEN'(2);
          state_d = S_OPS;
        end
      end
      S_PAD: if (acc) begin
        pad_left_d = pad_left_q - 1'b1;
        if (pad_left_q == 2'd1) state_d = S_OPS;
      end
      S_OPS: if (acc) begin
        ops_d = ops_q | ((8*MAX_OPS)'(in_byte) << {idx_q, 3'b000});
        idx_d = idx_q + 1'b1;
        if (idx_q + 1'b1 == count_q) state_d = S_EMIT;
      end
      S_EMIT: if (hs) begin
        idx_d = '0;
        if (is_sw && ent_cnt != '0) begin
          rem_d   = ent_cnt;
          state_d = S_ENT;
        end else begin
          state_d = S_OPC;
        end
      end
      S_ENT: if (acc) begin
        // Entries shift in big-endian so the first byte ends up in [31:24].
        if (idx_q == '0) begin
          ops_d    = (8*MAX_OPS)'(in_byte);
          opc_pc_d = pc_q;
          kind_d   = 1'b1;
          count_d  = PARAM_LEN'(4);
          pad_d    = '0;
        end else begin
          ops_d[31:0] = {ops_q[23:0], in_byte};
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == PARAM_LEN'(3)) state_d = S_ENT_EMIT;
      end
      S_ENT_EMIT: if (hs) begin
        idx_d   = '0;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == 33'd1) ? S_OPC : S_ENT;
      end
      default: state_d = S_OPC;
    endcase

    if (restart) begin
      state_d  = S_OPC;
      pc_d     = '0;
      idx_d    = '0;
      rem_d    = '0;
      kind_d   = 1'b0;
      opcode_d = '0;
      wide_d   = 1'b0;
      pad_d    = '0;
      count_d  = '0;
      ops_d    = '0;
      opc_pc_d = '0;
    end

    valid_d    = (state_d == S_EMIT) || (state_d == S_ENT_EMIT);
    in_ready_d = !valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OPC;
      pc_q       <= '0;
      idx_q      <= '0;
      pad_left_q <= '0;
      rem_q      <= '0;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      kind_q     <= 1'b0;
      opcode_q   <= '0;
      wide_q     <= 1'b0;
      pad_q      <= '0;
      count_q    <= '0;
      ops_q      <= '0;
      opc_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      pad_left_q <= pad_left_d;
      rem_q      <= rem_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      kind_q     <= kind_d;
      opcode_q   <= opcode_d;
      wide_q     <= wide_d;
      pad_q      <= pad_d;
      count_q    <= count_d;
      ops_q      <= ops_d;
      opc_pc_q   <= opc_pc_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = valid_q;
  assign out_kind     = kind_q;
  assign out_opcode   = opcode_q;
  assign out_wide     = wide_q;
  assign out_pad      = pad_q;
  assign out_count    = count_q;
  assign out_operands = ops_q;
  assign out_pc       = opc_pc_q;

endmodule

// File: doc/jvm_insn_framer.md
# jvm_insn_framer

Streaming JVM bytecode framer placed between the bytecode fetch buffer and the translation state machine. It accepts one bytecode byte per cycle and finds instruction boundaries using an internal operand-length table. It handles the `wide` prefix and the padding and jump tables of `tableswitch`/`lookupswitch`. Each framed instruction, and each jump-table entry, is emitted as one registered output beat carrying the opcode, packed operands, operand count and PC.

## Interface
- PARAM_LEN, 5: width of operand-count fields.
- PC_W, 16: width of byte PC.
- MAX_OPS, 12: operand byte capacity of `out_operands`; must be ≥12.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous flush: drop partial instruction and output beat, PC←0.
- in_valid  in  1  `in_byte` valid.
- in_ready  out  1  framer accepts byte this cycle.
- in_byte  in  8  bytecode byte.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_kind  out  1  0 = instruction, 1 = jump-table entry.
- out_opcode  out  8  opcode (the opcode after `wide` when prefixed).
- out_wide  out  1  instruction was `wide`-prefixed.
- out_pad  out  2  padding bytes skipped (switch opcodes only).
- out_count  out  PARAM_LEN  operand bytes in beat.
- out_operands  out  8*MAX_OPS  operand byte i at [8i+7:8i]; unused bits zero.
- out_pc  out  PC_W  PC of opcode byte (`wide` byte if prefixed); for entries, PC of first entry byte.

## Operation
- Length table (operand bytes):
  - 1: 10,12,15–19,36–3A,A9,BC.
  - 2: 11,13,14,84,99–A8,B2–B8,BB,BD,C0,C1,C6,C7.
  - 3: C5.
  - 4: B9,BA,C8,C9.
  - Switch: AA (12-byte header), AB (8-byte header).
  - All other opcodes: 0 operands.
- PC increments by 1 per accepted byte, wraps modulo 2^PC_W, and counts padding bytes and the `wide` byte.
- FSM states: OPC, WIDE, OPS, PAD, EMIT, ENT, ENT_EMIT.
  - **OPC:** accept opcode and latch PC.
    - C4 → WIDE.
    - AA/AB → PAD. pad = (4 − ((pc+1) mod 4)) mod 4; if pad = 0 go directly to OPS.
    - count 0 → EMIT.
    - otherwise → OPS.
  - **WIDE:** accept the next opcode and set wide = 1. Operands are 4 if the opcode is 84, else 2 → OPS.
  - **PAD:** discard pad bytes → OPS.
  - **OPS:** collect `count` bytes into operand bytes 0..count−1 → EMIT.
  - **EMIT:** hold the beat until out_valid && out_ready.
    - Non-switch → OPC.
    - Switch with remaining entries ≠ 0 → ENT.
    - Otherwise → OPC.
  - **ENT:** collect 4 bytes → ENT_EMIT.
  - **ENT_EMIT:** on handshake, decrement remaining. → ENT if nonzero, else → OPC.
- Entry count (32-bit, big-endian operand words):
  - tableswitch: high(bytes 8–11) − low(4–7) + 1, signed; 0 if high < low.
  - lookupswitch: 2·npairs(4–7); 0 if npairs ≤ 0.
  - Entry beat fields:
    - out_kind = 1 and out_count = 4.
    - out_operands[31:0] = the 4 bytes, big-endian assembled, so the first byte lands in [31:24].
    - out_opcode = switch opcode; out_pad = 0.
- The `wide` prefix followed by C4 is treated as a plain opcode with 0 operands, and wide is set.
- in_ready = 1 in OPC, WIDE, PAD, OPS, ENT; 0 in EMIT, ENT_EMIT.
- restart has priority over all activity. Next cycle: state OPC, PC 0, out_valid 0.

## Timing
- Reset (async assert, sync-safe release) sets:
  - state OPC, PC 0, out_valid 0, all out_* fields 0;
  - in_ready 1 once released.
- All outputs are registered.
- Latency:
  - A beat becomes valid the cycle after its last byte is accepted (for 0-operand instructions, the opcode byte).
  - Next byte accepted the cycle after the out handshake. Minimum throughput is count+2 cycles per instruction.
- Output fields are stable while out_valid && !out_ready.
- in_valid low mid-instruction stalls collection without loss; out_ready low stalls input via in_ready.
- rst_n low mid-operation aborts immediately with no beat emitted.

## Test plan
- Stream 10 05 60 B1 from reset, out_ready = 1 → beats:
  - (10, count 1, ops 05, pc 0);
  - (60, count 0, pc 2);
  - (B1, count 0, pc 3).
- Stream C4 84 01 02 00 10 → one beat: opcode 84, wide 1, count 4, ops 01 02 00 10, pc 0.
- Bytes 00 AA at pc 0–1, then 2 pad bytes, then default 0000_0010, low 0000_0001, high 0000_0003, then 3 entries → expected beats:
  - header: pad 2, count 12, pc 1;
  - 3 entry beats at pc 16, 20, 24.
- lookupswitch with npairs = 0 → header beat only, then next opcode framed normally.
- Hold out_ready = 0 for 5 cycles on beat 10 07 → beat is stable and in_ready is 0; following byte accepted one cycle after the handshake.
- Assert restart after C5 01 (mid-OPS) → no beat; next stream 00 framed at pc 0.
